// File: rtl/pe_stream_tx.sv
// Frames one (dest, len) command plus len stream words onto the 64-bit PE link; header goes out 1 cycle after accept, each beat 1 cycle after acceptance.
// Backpressure: Q_BP is registered (BP_R) and gates both header emission and S_TREADY, giving the PE a 1-cycle reaction window.
module pe_stream_tx #(
  parameter logic [15:0] HDR_TAG = 16'hFC01,
  parameter int          LEN_W   = 32
) (
  input  logic             CLK,
  input  logic             SYS_RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [15:0]      CMD_DEST,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic [63:0]      S_TDATA,
  input  logic             S_TVALID,
  output logic             S_TREADY,
  output logic [63:0]      Q,
  output logic             Q_VALID,
  input  logic             Q_BP,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {IDLE, HDR, BODY, FIN} state_t;

  state_t             state, state_nxt;
  logic [15:0]        dest_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   cnt;
  logic               bp_r;
  logic               cmd_acc;
  logic               hdr_send;
  logic               beat_acc;

  always_ff @(posedge CLK or posedge SYS_RST) begin
    if (SYS_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    CMD_READY = 1'b0;
    S_TREADY  = 1'b0;
    cmd_acc   = 1'b0;
    hdr_send  = 1'b0;
    beat_acc  = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          cmd_acc   = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (!bp_r) begin
          hdr_send  = 1'b1;
          state_nxt = (len_r == '0) ? FIN : BODY;
        end
      end
      BODY: begin
        S_TREADY = !bp_r;
        if (S_TVALID && !bp_r) begin
          beat_acc = 1'b1;
          // counter holds words still owed, so the last beat exits with it at 1
          if (cnt == LEN_W'(1)) state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      Q       <= '0;
      Q_VALID <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      cnt     <= '0;
      dest_r  <= '0;
      len_r   <= '0;
      bp_r    <= 1'b1;
    end else begin
      bp_r    <= Q_BP;
      DONE    <= (state == FIN);
      Q_VALID <= hdr_send || beat_acc;
      if (cmd_acc) begin
        dest_r <= CMD_DEST;
        len_r  <= CMD_LEN;
        cnt    <= CMD_LEN;
        BUSY   <= 1'b1;
      end
      if (hdr_send) Q <= {HDR_TAG, dest_r, 32'(len_r)};
      if (beat_acc) begin
        Q   <= S_TDATA;
        cnt <= cnt - LEN_W'(1);
      end
      if (state == FIN) BUSY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_stream_tx.sv
// Directed bench for pe_stream_tx: a word-queue model of the link plus per-cycle protocol rules.
module tb_pe_stream_tx;

  logic        CLK = 1'b0;
  logic        SYS_RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [15:0] CMD_DEST;
  logic [31:0] CMD_LEN;
  logic [63:0] S_TDATA;
  logic        S_TVALID;
  logic        S_TREADY;
  logic [63:0] Q;
  logic        Q_VALID;
  logic        Q_BP;
  logic        BUSY;
  logic        DONE;

  pe_stream_tx dut (
    .CLK(CLK), .SYS_RST(SYS_RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DEST(CMD_DEST), .CMD_LEN(CMD_LEN),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .Q(Q), .Q_VALID(Q_VALID), .Q_BP(Q_BP), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] seen[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Link model: every frame is header then payload in order; rules are checked each cycle.
  task automatic monitor();
    bit prev_take = 1'b0;
    bit prev_done = 1'b0;
    bit bp_model  = 1'b1;
    int cyc       = 0;
    int last_qv   = -10;
    forever begin
      @(negedge CLK);
      cyc++;
      if (SYS_RST) begin
        exp_q.delete();
        prev_take = 1'b0;
        prev_done = 1'b0;
        bp_model  = 1'b1;
        continue;
      end
      if (prev_take) check("beat latency", 64'(Q_VALID), 64'd1);
      if (bp_model) check("tready under bp", 64'(S_TREADY), 64'd0);
      if (DONE) begin
        done_cnt++;
        check("done after last word", 64'(cyc - last_qv), 64'd1);
        check("done single pulse", 64'(prev_done), 64'd0);
      end
      if (Q_VALID) begin
        seen.push_back(Q);
        if (exp_q.size() == 0) check("unexpected link word", 64'(Q_VALID), 64'd0);
        else                   check("link word", Q, exp_q.pop_front());
        last_qv = cyc;
      end
      prev_done = DONE;
      prev_take = S_TVALID && S_TREADY;
      bp_model  = Q_BP;
    end
  endtask

  task automatic run_frame(input logic [15:0] dest, input logic [31:0] len, input logic [63:0] base,
                           input bit toggle, input int bp_start, input int bp_len, input int abort_at,
                           output int acc_wait, output int low_cnt);
    int idx = 0;
    int cyc = 0;
    bit took;
    bit acc = 1'b0;
    bit got = 1'b0;
    exp_q.push_back({16'hFC01, dest, len});
    for (int i = 0; i < int'(len); i++) exp_q.push_back(base + 64'(i));
    CMD_VALID = 1'b1;
    CMD_DEST  = dest;
    CMD_LEN   = len;
    acc_wait  = 0;
    low_cnt   = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      if (CMD_READY) acc = 1'b1;
      else           acc_wait++;
      @(posedge CLK); #1;
    end
    // junk on the command bus afterwards must not leak into the frame
    CMD_VALID = 1'b0;
    CMD_DEST  = 16'hDEAD;
    CMD_LEN   = 32'h55;
    check("cmd accepted", 64'(acc), 64'd1);
    check("busy after accept", 64'(BUSY), 64'd1);
    while (idx < int'(len) && cyc < 200 && idx != abort_at) begin
      S_TVALID = toggle ? (cyc % 2 == 0) : 1'b1;
      S_TDATA  = base + 64'(idx);
      Q_BP     = (cyc >= bp_start) && (cyc < bp_start + bp_len);
      @(negedge CLK);
      took = S_TVALID && S_TREADY;
      if (idx >= 1 && !S_TREADY) low_cnt++;
      @(posedge CLK); #1;
      if (took) idx++;
      cyc++;
    end
    S_TVALID = 1'b0;
    Q_BP     = 1'b0;
    if (abort_at < 0) begin
      check("all beats accepted", 64'(idx), 64'(len));
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge CLK);
        if (len == 0) check("no tready for empty frame", 64'(S_TREADY), 64'd0);
        if (DONE) got = 1'b1;
      end
      check("done seen", 64'(got), 64'd1);
      check("busy cleared at done", 64'(BUSY), 64'd0);
      check("model queue drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  initial begin
    int          mark, dc, aw, lc;
    logic [63:0] lit1 [5];
    lit1 = '{64'hFC01_0003_0000_0004, 64'd1, 64'd2, 64'd3, 64'd4};

    fork
      monitor();
      begin
        #100000;
        $display("FAIL timeout: bench did not complete within time budget");
        $fatal(1, "timeout");
      end
    join_none

    SYS_RST = 1'b1; CMD_VALID = 1'b0; CMD_DEST = '0; CMD_LEN = '0;
    S_TDATA = '0; S_TVALID = 1'b0; Q_BP = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset Q", Q, 64'd0);
    check("reset Q_VALID", 64'(Q_VALID), 64'd0);
    check("reset S_TREADY", 64'(S_TREADY), 64'd0);
    check("reset BUSY", 64'(BUSY), 64'd0);
    check("reset DONE", 64'(DONE), 64'd0);
    check("reset CMD_READY", 64'(CMD_READY), 64'd1);
    SYS_RST = 1'b0;
    @(posedge CLK); #1;

    // 1) basic 4-word frame
    mark = seen.size(); dc = done_cnt;
    run_frame(16'h0003, 32'd4, 64'd1, 1'b0, 1000, 0, -1, aw, lc);
    check("t1 header accepted immediately", 64'(aw), 64'd0);
    @(posedge CLK); #1;
    check("t1 link word count", 64'(seen.size() - mark), 64'd5);
    for (int i = 0; i < 5; i++) check("t1 literal word", seen[mark + i], lit1[i]);
    check("t1 done count", 64'(done_cnt - dc), 64'd1);

    // 2) empty frame: header only
    mark = seen.size();
    run_frame(16'h0007, 32'd0, 64'd0, 1'b0, 1000, 0, -1, aw, lc);
    @(posedge CLK); #1;
    check("t2 link word count", 64'(seen.size() - mark), 64'd1);
    check("t2 literal header", seen[mark], 64'hFC01_0007_0000_0000);

    // 3) backpressure mid-body
    mark = seen.size();
    run_frame(16'h0011, 32'd8, 64'hA0, 1'b0, 4, 3, -1, aw, lc);
    @(posedge CLK); #1;
    check("t3 tready low cycles", 64'(lc), 64'd3);
    check("t3 link word count", 64'(seen.size() - mark), 64'd9);

    // 4) gappy source
    mark = seen.size();
    run_frame(16'h0022, 32'd6, 64'hB0, 1'b1, 1000, 0, -1, aw, lc);
    @(posedge CLK); #1;
    check("t4 link word count", 64'(seen.size() - mark), 64'd7);

    // 5) async reset after 3 of 6 payload words
    mark = seen.size(); dc = done_cnt;
    run_frame(16'h0005, 32'd6, 64'hC0, 1'b0, 1000, 0, 3, aw, lc);
    @(negedge CLK); #1;
    SYS_RST = 1'b1;
    #1;
    check("t5 Q_VALID drops async", 64'(Q_VALID), 64'd0);
    check("t5 BUSY drops async", 64'(BUSY), 64'd0);
    check("t5 S_TREADY drops async", 64'(S_TREADY), 64'd0);
    @(posedge CLK); @(posedge CLK); #1;
    SYS_RST = 1'b0;
    check("t5 CMD_READY after reset", 64'(CMD_READY), 64'd1);
    check("t5 words before abort", 64'(seen.size() - mark), 64'd4);
    check("t5 no done on abort", 64'(done_cnt - dc), 64'd0);
    @(posedge CLK); #1;
    mark = seen.size();
    run_frame(16'h0006, 32'd2, 64'hD0, 1'b0, 1000, 0, -1, aw, lc);
    @(posedge CLK); #1;
    check("t5 clean frame count", 64'(seen.size() - mark), 64'd3);

    // 6) back-to-back: second command is offered in the DONE cycle
    mark = seen.size();
    run_frame(16'h0008, 32'd3, 64'hE0, 1'b0, 1000, 0, -1, aw, lc);
    check("t6 ready during done", 64'(CMD_READY), 64'd1);
    run_frame(16'h0009, 32'd2, 64'hF0, 1'b0, 1000, 0, -1, aw, lc);
    check("t6 second cmd no wait", 64'(aw), 64'd0);
    @(posedge CLK); #1;
    check("t6 link word count", 64'(seen.size() - mark), 64'd7);

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
